// File: rtl/mult_stream_seq_if.sv
// Handshake bundle for mult_stream_seq: operand stream in, multiplier side-channel, product stream out.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high; valid must hold until then.
interface mult_stream_seq_if #(
  parameter int BITS = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   in_a;
  logic [BITS-1:0]   in_b;

  logic              mul_start;
  logic [BITS-1:0]   mul_a;
  logic [BITS-1:0]   mul_b;
  logic              mul_ready;
  logic [2*BITS:0]   mul_product;

  logic              out_valid;
  logic              out_ready;
  logic [2*BITS:0]   out_product;

  modport slave (
    input  in_valid, in_a, in_b, mul_ready, mul_product, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_product
  );

  modport master (
    output in_valid, in_a, in_b, mul_ready, mul_product, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product
  );
endinterface

// File: rtl/mult_stream_seq.sv
// Sequencer that feeds operand pairs from a 2-deep FIFO to an external shift-add
// multiplier, one at a time, and holds each product until downstream takes it.
module mult_stream_seq #(
  parameter int BITS    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  mult_stream_seq_if.slave  bus,
  output logic              busy,
  output logic              err,
  output logic [7:0]        done_count,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic              capture;
  logic              tmo_fire;
  logic              push;

  logic [2*BITS-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;

  logic [BITS-1:0]   op_a;
  logic [BITS-1:0]   op_b;
  logic [6:0]        tmo_cnt;
  logic              out_valid_q;
  logic [2*BITS:0]   out_product_q;
  logic              err_q;
  logic [7:0]        done_q;

  assign push = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        // never start a new product while the previous one is still unconsumed
        if (fifo_cnt != 2'd0 && !out_valid_q) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = ARM;
      // the multiplier drops ready one cycle after start, so ready is not trusted here
      ARM:   state_nxt = WAIT;
      WAIT: begin
        if (bus.mul_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
      op_a          <= '0;
      op_b          <= '0;
      tmo_cnt       <= 7'd0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      err_q         <= 1'b0;
      done_q        <= 8'd0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (issue) begin
        rd_ptr          <= ~rd_ptr;
        {op_a, op_b}    <= fifo_mem[rd_ptr];
      end
      case ({push, issue})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (issue)                             tmo_cnt <= 7'd0;
      else if (state == WAIT && !bus.mul_ready) tmo_cnt <= tmo_cnt + 7'd1;

      if (capture) begin
        out_product_q <= bus.mul_product;
        out_valid_q   <= 1'b1;
        done_q        <= done_q + 8'd1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q   <= 1'b0;
      end

      if (tmo_fire) err_q <= 1'b1;
    end
  end

  assign bus.in_ready    = (fifo_cnt != 2'd2);
  assign bus.mul_start   = (state == ISSUE);
  assign bus.mul_a       = op_a;
  assign bus.mul_b       = op_b;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign busy            = (state != IDLE);
  assign err             = err_q;
  assign done_count      = done_q;
  assign fsm_state       = state;

endmodule

// File: tb/tb_mult_stream_seq.sv
// Directed bench for mult_stream_seq: vector table through a behavioural multiplier,
// plus hand sequences for latency, back-pressure, timeout, async reset and counter wrap.
module tb_mult_stream_seq;
  localparam int BITS = 8;
  localparam int PW   = 2*BITS+1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_stream_seq_if #(.BITS(BITS)) bus();
  logic       busy;
  logic       err;
  logic [7:0] done_count;
  logic [1:0] fsm_state;

  mult_stream_seq #(.BITS(BITS), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .err        (err),
    .done_count (done_count),
    .fsm_state  (fsm_state)
  );

  // behavioural shift-add multiplier: ready drops for mdl_delay cycles after start
  int unsigned    mdl_delay     = 10;
  logic           mdl_hang      = 1'b0;
  logic           mdl_force     = 1'b0;
  logic [PW-1:0]  mdl_force_val = '0;
  logic           mdl_ready;
  logic [PW-1:0]  mdl_prod;
  int unsigned    mdl_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_ready <= 1'b1;
      mdl_prod  <= '0;
      mdl_cnt   <= 0;
    end else if (bus.mul_start) begin
      mdl_ready <= 1'b0;
      mdl_cnt   <= mdl_delay;
      mdl_prod  <= mdl_force ? mdl_force_val : PW'(bus.mul_a) * PW'(bus.mul_b);
    end else if (!mdl_ready && !mdl_hang) begin
      if (mdl_cnt <= 1) mdl_ready <= 1'b1;
      else              mdl_cnt   <= mdl_cnt - 1;
    end
  end

  assign bus.mul_ready   = mdl_ready;
  assign bus.mul_product = mdl_prod;

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] sb_exp;
  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.mul_start) start_cnt++;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.out_product), 32'hFFFF_FFFF);
      end else begin
        sb_exp = exp_q.pop_front();
        check("product", 32'(bus.out_product), 32'(sb_exp));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 500) begin
      tick();
      n++;
    end
    check("push_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},        32'(busy),            32'd0);
    check({tag, "_err"},         32'(err),             32'd0);
    check({tag, "_done"},        32'(done_count),      32'd0);
    check({tag, "_in_ready"},    32'(bus.in_ready),    32'd1);
    check({tag, "_mul_start"},   32'(bus.mul_start),   32'd0);
    check({tag, "_mul_a"},       32'(bus.mul_a),       32'd0);
    check({tag, "_mul_b"},       32'(bus.mul_b),       32'd0);
    check({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
    check({tag, "_out_product"}, 32'(bus.out_product), 32'd0);
    check({tag, "_state"},       32'(fsm_state),       32'd0);
  endtask

  typedef struct {
    logic [7:0]    a;
    logic [7:0]    b;
    logic [PW-1:0] prod;
    int unsigned   delay;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [PW-1:0] e;

    vecs[0] = '{a: 8'd255, b: 8'd255, prod: 17'd65025, delay: 3};
    vecs[1] = '{a: 8'd0,   b: 8'd200, prod: 17'd0,     delay: 1};
    vecs[2] = '{a: 8'd13,  b: 8'd11,  prod: 17'd143,   delay: 10};
    vecs[3] = '{a: 8'd1,   b: 8'd1,   prod: 17'd1,     delay: 2};
    vecs[4] = '{a: 8'd200, b: 8'd0,   prod: 17'd0,     delay: 5};
    vecs[5] = '{a: 8'd128, b: 8'd2,   prod: 17'd256,   delay: 4};
    vecs[6] = '{a: 8'd255, b: 8'd1,   prod: 17'd255,   delay: 1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;

    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b1;

    // basic 13*11 with latency and pulse-width checks, result held under back-pressure
    mdl_delay     = 10;
    bus.out_ready = 1'b0;
    s0            = start_cnt;
    push(8'd13, 8'd11);
    check("lat_idle_start", 32'(bus.mul_start), 32'd0);
    tick();
    check("lat_start",      32'(bus.mul_start), 32'd1);
    check("lat_busy",       32'(busy),          32'd1);
    tick();
    check("start_width",    32'(bus.mul_start), 32'd0);
    wait_out_valid(50);
    check("basic_product",  32'(bus.out_product), 32'd143);
    check("basic_done",     32'(done_count),      32'd1);
    check("basic_starts",   32'(start_cnt - s0),  32'd1);
    exp_q.push_back(17'd143);
    bus.out_ready = 1'b1;
    wait_drain(10);
    tick();
    check("basic_cleared",  32'(bus.out_valid), 32'd0);

    // back-pressure: first result held, FIFO fills with the other two
    bus.out_ready = 1'b0;
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    check("bp_full", 32'(bus.in_ready), 32'd0);
    wait_out_valid(50);
    check("bp_first", 32'(bus.out_product), 32'd12);
    repeat (5) tick();
    check("bp_hold_valid",   32'(bus.out_valid),   32'd1);
    check("bp_hold_product", 32'(bus.out_product), 32'd12);
    check("bp_hold_full",    32'(bus.in_ready),    32'd0);
    check("bp_no_issue",     32'(busy),            32'd0);
    exp_q.push_back(17'd12);
    exp_q.push_back(17'd30);
    exp_q.push_back(17'd56);
    bus.out_ready = 1'b1;
    wait_drain(200);
    check("bp_done", 32'(done_count), 32'd4);

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      mdl_delay = vecs[i].delay;
      s0        = start_cnt;
      exp_q.push_back(vecs[i].prod);
      push(vecs[i].a, vecs[i].b);
      wait_drain(100);
      tick();
      check($sformatf("vec%0d_done", i),   32'(done_count),     32'(5 + i));
      check($sformatf("vec%0d_starts", i), 32'(start_cnt - s0), 32'd1);
    end

    // full-width product passes through untouched, including the top bit
    mdl_force     = 1'b1;
    mdl_force_val = 17'h1_2345;
    mdl_delay     = 2;
    exp_q.push_back(17'h1_2345);
    push(8'd1, 8'd1);
    wait_drain(100);
    mdl_force     = 1'b0;

    // timeout: multiplier never comes back
    mdl_hang  = 1'b1;
    mdl_delay = 1;
    push(8'd9, 8'd9);
    tick();
    check("to_start", 32'(bus.mul_start), 32'd1);
    tick();
    tick();
    repeat (63) tick();
    check("to_err_early",  32'(err),  32'd0);
    check("to_busy_early", 32'(busy), 32'd1);
    tick();
    check("to_err",        32'(err),           32'd1);
    check("to_idle",       32'(busy),          32'd0);
    check("to_no_result",  32'(bus.out_valid), 32'd0);
    check("to_done",       32'(done_count),    32'd12);
    mdl_hang  = 1'b0;
    mdl_delay = 4;
    exp_q.push_back(17'd42);
    push(8'd6, 8'd7);
    wait_drain(100);
    check("err_sticky",    32'(err),        32'd1);
    check("after_to_done", 32'(done_count), 32'd13);

    // asynchronous reset in the middle of WAIT
    mdl_delay = 20;
    push(8'd10, 8'd10);
    repeat (6) tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    rst = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    mdl_delay = 3;
    exp_q.push_back(17'd6);
    push(8'd2, 8'd3);
    wait_drain(100);
    check("post_rst_done", 32'(done_count), 32'd1);

    // done_count wrap: 255 more completions after the one above
    mdl_delay = 1;
    for (int i = 0; i < 254; i++) begin
      e = 17'(i) * 17'd3;
      exp_q.push_back(e);
      push(8'(i), 8'd3);
    end
    wait_drain(5000);
    check("wrap_255", 32'(done_count), 32'd255);
    exp_q.push_back(17'd762);
    push(8'd254, 8'd3);
    wait_drain(100);
    check("wrap_zero", 32'(done_count), 32'd0);

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_stream_seq.md
MULT_STREAM_SEQ -- requirements
Module: mult_stream_seq

Interface
REQ-001 Parameter BITS, default 8, is the operand width in bits.
REQ-002 Parameter TIMEOUT, default 64, is the maximum number of WAIT cycles allowed for a multiplier response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand FIFO can accept; equals not-full.
REQ-007 in_a  input  BITS  multiplicand.
REQ-008 in_b  input  BITS  multiplier.
REQ-009 mul_start  output  1  one-cycle start pulse to the shift-add multiplier.
REQ-010 mul_a  output  BITS  multiplicand to the multiplier; driven from the operand register.
REQ-011 mul_b  output  BITS  multiplier operand to the multiplier; driven from the operand register.
REQ-012 mul_ready  input  1  multiplier idle / product valid (level).
REQ-013 mul_product  input  2*BITS+1  multiplier result.
REQ-014 out_valid  output  1  result register holds an unconsumed product.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_product  output  2*BITS+1  registered product.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 err  output  1  sticky timeout flag.
REQ-019 done_count  output  8  count of products delivered into the result register.

Function
REQ-020 Operand FIFO: 2 entries of {in_a,in_b}; a push occurs on an edge where in_valid and in_ready are both high; order is strictly FIFO.
REQ-021 FSM states are IDLE, ISSUE, ARM and WAIT.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty and out_valid=0; on that edge the FIFO head is loaded into the operand register and popped.
REQ-023 ISSUE: mul_start=1 for exactly this one cycle, then -> ARM.
REQ-024 ARM: mul_ready is ignored for this one cycle (the multiplier drops Ready after Start), then -> WAIT.
REQ-025 WAIT with mul_ready=1: mul_product is captured into out_product, out_valid is set, done_count increments, and the FSM returns to IDLE.
REQ-026 WAIT with mul_ready=0: the 7-bit timeout counter increments; when it reaches TIMEOUT-1 with mul_ready still 0, err is set, no result is written, and the FSM returns to IDLE.
REQ-027 The timeout counter clears on entry to ISSUE.
REQ-028 mul_a and mul_b remain stable from ISSUE through the WAIT exit.
REQ-029 mul_product is captured without modification; it is 2*BITS+1 bits wide with no truncation.
REQ-030 out_valid holds, with out_product stable, until an edge where out_valid and out_ready are both high; that edge clears out_valid.
REQ-031 A new issue waits for out_valid=0; the FSM never overwrites an unconsumed result.
REQ-032 Minimum latency: mul_start is high 2 cycles after the accepting edge of an operand into an empty FIFO while in IDLE.
REQ-033 Simultaneous push and pop on the same edge keeps the FIFO occupancy unchanged.
REQ-034 A push is impossible when full because in_ready=0.
REQ-035 done_count wraps from 255 to 0.
REQ-036 err stays 1 until reset; operation continues normally after a timeout.

Reset
REQ-037 While rst=0, all of the following are forced immediately: FSM=IDLE, FIFO empty, in_ready=1, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_product=0, busy=0, err=0, done_count=0, timeout counter=0.
REQ-038 A reset mid-operation discards the in-flight operands and any unconsumed result.
REQ-039 The first push is possible on the first rising edge after rst returns to 1.

Verification
REQ-040 Basic: push in_a=13, in_b=11 with a model multiplier (Ready low for 10 cycles after Start) -> one mul_start pulse, out_product=143, out_valid=1, done_count=1.
REQ-041 Back-pressure: out_ready=0 while pushing (3,4), (5,6), (7,8) -> 12 is held, in_ready=0 after 2 queued pairs; after releasing out_ready, 12, 30 and 56 are delivered in order.
REQ-042 Boundary: 255*255 -> out_product=65025; 0*200 -> 0.
REQ-043 Timeout: model never reasserts mul_ready -> err=1 exactly 64 WAIT cycles after ARM, busy=0 afterwards, no out_valid; the next pair completes normally and err stays 1.
REQ-044 Reset mid-WAIT: drive rst=0 -> all outputs are at reset values in the same cycle; after release, a pushed pair 2*3 -> 6.
REQ-045 Wrap: 256 completed products -> done_count=0.
